// File: rtl/fpa_pipe_if.sv
// Operand/result stream bundle for the pipelined FP adder.
// master drives operands and out_ready; slave is the adder.
interface fpa_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] number_A;
  logic [W-1:0] number_B;
  logic         sub;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] number_out;
  logic         flag_invalid;
  logic         flag_overflow;
  logic         flag_inexact;

  modport master (
    output in_valid,
    output number_A,
    output number_B,
    output sub,
    output rnd_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  number_out,
    input  flag_invalid,
    input  flag_overflow,
    input  flag_inexact
  );

  modport slave (
    input  in_valid,
    input  number_A,
    input  number_B,
    input  sub,
    input  rnd_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output number_out,
    output flag_invalid,
    output flag_overflow,
    output flag_inexact
  );
endinterface

// File: rtl/fpa_pipe.sv
// Three-stage parametrised FP adder/subtractor.
// Stages: unpack/align, magnitude add, normalise/round/pack.
module fpa_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic      clk,
  input logic      rst_n,
  fpa_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int LW = $clog2(SW + 1);
  localparam int XW = ((EXP_W > LW) ? EXP_W : LW) + 2;

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [XW-1:0] EX_TOP =
    {{(XW-EXP_W){1'b0}}, EMAX};

  typedef struct packed {
    logic             v;
    logic             sp;
    logic             sp_inv;
    logic [W-1:0]     sp_res;
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    big;
    logic [SW-1:0]    sml;
    logic             esub;
    logic             rnd;
  } s1_t;

  typedef struct packed {
    logic             v;
    logic             sp;
    logic             sp_inv;
    logic [W-1:0]     sp_res;
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
    logic             rnd;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic en;

  assign en = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, b_nan;
  logic             a_inf, b_inf;
  logic             a_zero, b_zero;

  assign sa = bus.number_A[W-1];
  assign ea = bus.number_A[W-2:MAN_W];
  assign fa = bus.number_A[MAN_W-1:0];
  assign sb = bus.number_B[W-1] ^ bus.sub;
  assign eb = bus.number_B[W-2:MAN_W];
  assign fb = bus.number_B[MAN_W-1:0];

  assign a_nan  = (ea == EMAX) & (|fa);
  assign b_nan  = (eb == EMAX) & (|fb);
  assign a_inf  = (ea == EMAX) & ~(|fa);
  assign b_inf  = (eb == EMAX) & ~(|fb);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  logic               swap;
  logic [EXP_W-1:0]   diff;
  logic [2*SW-1:0]    wide;
  int unsigned        sh;

  always_comb begin
    s1_d      = '0;
    s1_d.v    = bus.in_valid;
    s1_d.rnd  = bus.rnd_mode;
    s1_d.esub = sa ^ sb;
    s1_d.sp   = 1'b1;
    if (a_nan | b_nan) begin
      s1_d.sp_res = QNAN;
      s1_d.sp_inv = 1'b1;
    end else if (a_inf & b_inf & (sa ^ sb)) begin
      s1_d.sp_res = QNAN;
      s1_d.sp_inv = 1'b1;
    end else if (a_inf) begin
      s1_d.sp_res = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      s1_d.sp_res = {sb, EMAX, {MAN_W{1'b0}}};
    end else if (a_zero & b_zero) begin
      s1_d.sp_res = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      s1_d.sp_res = {sb, eb, fb};
    end else if (b_zero) begin
      s1_d.sp_res = {sa, ea, fa};
    end else begin
      s1_d.sp = 1'b0;
    end

    swap = {eb, fb} > {ea, fa};
    diff = swap ? eb - ea : ea - eb;
    sh   = (32'(diff) > SW) ? SW : 32'(diff);

    s1_d.sgn = swap ? sb : sa;
    s1_d.exp = swap ? eb : ea;
    s1_d.big = {1'b1, swap ? fb : fa, 3'b000};
    // Lower half collects everything shifted out.
    wide = {1'b1, swap ? fa : fb, 3'b000,
            {SW{1'b0}}} >> sh;
    s1_d.sml = wide[2*SW-1:SW] |
               {{(SW-1){1'b0}}, |wide[SW-1:0]};
  end

  always_comb begin
    s2_d        = '0;
    s2_d.v      = s1_q.v;
    s2_d.sp     = s1_q.sp;
    s2_d.sp_inv = s1_q.sp_inv;
    s2_d.sp_res = s1_q.sp_res;
    s2_d.sgn    = s1_q.sgn;
    s2_d.exp    = s1_q.exp;
    s2_d.rnd    = s1_q.rnd;
    if (s1_q.esub)
      s2_d.sum = {1'b0, s1_q.big} - {1'b0, s1_q.sml};
    else
      s2_d.sum = {1'b0, s1_q.big} + {1'b0, s1_q.sml};
  end

  logic [LW-1:0]    lzc;
  logic [SW-1:0]    norm;
  logic [MAN_W:0]   mant;
  logic             g, r, st, inc;
  logic [MAN_W+1:0] rsum;
  logic [XW-1:0]    exb, ex;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res;
  logic             f_inv, f_ovf, f_inx;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < SW; i++)
      if (s2_q.sum[i]) lzc = LW'(SW - 1 - i);
  end

  assign exb = {{(XW-EXP_W){1'b0}}, s2_q.exp};

  always_comb begin
    if (s2_q.sum[SW]) begin
      norm = {s2_q.sum[SW:2], |s2_q.sum[1:0]};
      ex   = exb + XW'(1);
    end else begin
      norm = s2_q.sum[SW-1:0] << lzc;
      ex   = exb - {{(XW-LW){1'b0}}, lzc};
    end
    mant = norm[SW-1:3];
    g    = norm[2];
    r    = norm[1];
    st   = norm[0];
    inc  = ~s2_q.rnd & g & (r | st | mant[0]);
    rsum = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
    frac = rsum[MAN_W-1:0];
    if (rsum[MAN_W+1]) begin
      ex   = ex + XW'(1);
      frac = rsum[MAN_W:1];
    end

    f_inv = 1'b0;
    f_ovf = 1'b0;
    f_inx = g | r | st;
    res   = {s2_q.sgn, ex[EXP_W-1:0], frac};

    if (s2_q.sp) begin
      res   = s2_q.sp_res;
      f_inv = s2_q.sp_inv;
      f_inx = 1'b0;
    end else if (s2_q.sum == '0) begin
      res   = '0;
      f_inx = 1'b0;
    end else if (!ex[XW-1] && ex >= EX_TOP) begin
      f_ovf = 1'b1;
      f_inx = 1'b1;
      // Truncation saturates at the largest finite value.
      if (s2_q.rnd)
        res = {s2_q.sgn, EMAX - EXP_W'(1),
               {MAN_W{1'b1}}};
      else
        res = {s2_q.sgn, EMAX, {MAN_W{1'b0}}};
    end else if (ex[XW-1] || ex == '0) begin
      res   = {s2_q.sgn, {(W-1){1'b0}}};
      f_inx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q              <= '0;
      s2_q              <= '0;
      bus.out_valid     <= 1'b0;
      bus.number_out    <= '0;
      bus.flag_invalid  <= 1'b0;
      bus.flag_overflow <= 1'b0;
      bus.flag_inexact  <= 1'b0;
    end else if (en) begin
      s1_q              <= s1_d;
      s2_q              <= s2_d;
      bus.out_valid     <= s2_q.v;
      bus.number_out    <= res;
      bus.flag_invalid  <= s2_q.v & f_inv;
      bus.flag_overflow <= s2_q.v & f_ovf;
      bus.flag_inexact  <= s2_q.v & f_inx;
    end
  end

endmodule

// File: tb/tb_fpa_pipe.sv
// Bench for fpa_pipe: directed FP32 cases plus random
// streams scored against an exact-arithmetic model.
module tb_fpa_pipe;
  localparam int EW = 8;
  localparam int MW = 23;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        rm;
    logic [34:0] exp;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpa_pipe_if #(.EXP_W(EW), .MAN_W(MW)) bus();

  fpa_pipe #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int out_cyc = 0;
  op_t pend[$];
  logic [34:0] sb_q[$];
  bit presenting = 0;
  bit stalled = 0;
  bit saw_stall = 0;
  logic [35:0] held;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Exact sum of the two values, then IEEE rounding.
  function automatic logic [34:0] fp_ref(
    input logic [31:0] a, b,
    input logic sub, rm);
    logic sa, sb_, sg, inx;
    int ea, eb, p, sh, ex;
    logic [22:0] fa, fb;
    logic [299:0] ma, mb, mag, rem, half, keep;
    sa = a[31]; sb_ = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0))
      return {3'b100, QNAN};
    if (ea == 255 && eb == 255)
      return (sa != sb_) ? {3'b100, QNAN}
                         : {3'b000, sa, 8'hFF, 23'h0};
    if (ea == 255) return {3'b000, sa, 8'hFF, 23'h0};
    if (eb == 255) return {3'b000, sb_, 8'hFF, 23'h0};
    if (ea == 0 && eb == 0)
      return {3'b000, sa & sb_, 31'h0};
    if (ea == 0) return {3'b000, sb_, b[30:0]};
    if (eb == 0) return {3'b000, a};
    ma = 300'({1'b1, fa}) << (ea - 1);
    mb = 300'({1'b1, fb}) << (eb - 1);
    if (sa == sb_) begin mag = ma + mb; sg = sa; end
    else if (ma >= mb) begin mag = ma - mb; sg = sa; end
    else begin mag = mb - ma; sg = sb_; end
    if (mag == 0) return 35'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    ex = p - 22;
    rem = 0; half = 1;
    if (p > 23) begin
      sh = p - 23;
      keep = mag >> sh;
      rem = mag & ((300'd1 << sh) - 1);
      half = 300'd1 << (sh - 1);
    end else begin
      keep = mag << (23 - p);
    end
    inx = (rem != 0);
    if (!rm && rem != 0 &&
        (rem > half || (rem == half && keep[0])))
      keep = keep + 1;
    if (keep[24]) begin keep = keep >> 1; ex++; end
    if (ex >= 255)
      return {3'b011, rm ? {sg, 8'hFE, 23'h7FFFFF}
                         : {sg, 8'hFF, 23'h0}};
    if (ex <= 0) return {3'b001, sg, 31'h0};
    return {2'b00, inx, sg, 8'(ex), keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_val(input int base);
    logic s;
    int e;
    logic [22:0] f;
    s = 1'($urandom);
    f = 23'($urandom);
    if ($urandom_range(3) == 0) f = f & 23'h7FFF00;
    case ($urandom_range(19))
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 1'b1, f[21:0]};
      3: return {s, 8'h00, f};
      4: return {s, 8'hFE, 23'h7FFFFF};
      default: begin
        e = base + int'($urandom_range(60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {s, 8'(e), f};
      end
    endcase
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int base;
    base = ($urandom_range(3) == 0)
         ? int'($urandom_range(1, 12))
         : int'($urandom_range(1, 254));
    o.a = rnd_val(base);
    o.b = rnd_val(base);
    o.sub = 1'($urandom);
    o.rm = ($urandom_range(3) == 0);
    o.exp = fp_ref(o.a, o.b, o.sub, o.rm);
    return o;
  endfunction

  function automatic op_t dop(
    input logic [31:0] a, b, input logic sub, rm,
    input logic [31:0] res, input logic [2:0] fl);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.rm = rm;
    o.exp = {fl, res};
    return o;
  endfunction

  task automatic cycle(input bit rdy, input bit vok);
    @(negedge clk);
    cyc++;
    bus.out_ready = rdy;
    if (!presenting && vok && pend.size() > 0) begin
      presenting = 1;
      bus.number_A = pend[0].a;
      bus.number_B = pend[0].b;
      bus.sub = pend[0].sub;
      bus.rnd_mode = pend[0].rm;
    end
    bus.in_valid = presenting;
    #1;
    check("in_ready", bus.in_ready,
          !bus.out_valid || bus.out_ready);
    if (!bus.in_ready) saw_stall = 1;
    if (stalled)
      check("hold", {bus.out_valid, bus.flag_invalid,
            bus.flag_overflow, bus.flag_inexact,
            bus.number_out}, held);
    stalled = bus.out_valid && !bus.out_ready;
    held = {bus.out_valid, bus.flag_invalid,
            bus.flag_overflow, bus.flag_inexact,
            bus.number_out};
    if (bus.out_valid && bus.out_ready) begin
      out_cyc = cyc;
      if (sb_q.size() == 0)
        check("extra_out", bus.out_valid, 0);
      else
        check("result", held[34:0], sb_q.pop_front());
    end
    if (presenting && bus.in_ready) begin
      sb_q.push_back(pend[0].exp);
      pend.delete(0);
      presenting = 0;
      hs_cyc = cyc;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb_q.size() > 0; k++)
      cycle(1, 0);
    check("drain", sb_q.size(), 0);
  endtask

  task automatic feed(input int rpct, input int vpct);
    for (int k = 0; k < 6000 && pend.size() > 0; k++)
      cycle($urandom_range(99) < rpct,
            $urandom_range(99) < vpct);
    check("feed", pend.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.number_A = '0;
    bus.number_B = '0;
    bus.sub = 0;
    bus.rnd_mode = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_out", bus.number_out, 0);
    check("rst_flags", {bus.flag_invalid,
          bus.flag_overflow, bus.flag_inexact}, 0);
    check("rst_ready", bus.in_ready, 1);
    rst_n = 1;

    pend.push_back(dop(32'h3F800000, 32'h40000000,
                       0, 0, 32'h40400000, 3'b000));
    cycle(1, 1);
    for (int k = 0; k < 10 && sb_q.size() > 0; k++)
      cycle(1, 0);
    check("latency", out_cyc - hs_cyc, 3);
    drain();

    pend.push_back(dop(32'h3F800000, 32'h3F800000,
                       1, 0, 32'h00000000, 3'b000));
    pend.push_back(dop(32'h80000000, 32'h80000000,
                       0, 0, 32'h80000000, 3'b000));
    pend.push_back(dop(32'h7F800000, 32'hFF800000,
                       0, 0, QNAN, 3'b100));
    pend.push_back(dop(32'h7FC00001, 32'h3F800000,
                       0, 0, QNAN, 3'b100));
    pend.push_back(dop(32'h7F7FFFFF, 32'h7F7FFFFF,
                       0, 0, 32'h7F800000, 3'b011));
    pend.push_back(dop(32'h7F7FFFFF, 32'h7F7FFFFF,
                       0, 1, 32'h7F7FFFFF, 3'b011));
    pend.push_back(dop(32'h3F800000, 32'h33800000,
                       0, 0, 32'h3F800000, 3'b001));
    pend.push_back(dop(32'h3F800000, 32'h33C00000,
                       0, 0, 32'h3F800001, 3'b001));
    pend.push_back(dop(32'h3F800000, 32'h34000000,
                       0, 0, 32'h3F800001, 3'b000));
    pend.push_back(dop(32'h3F800000, 32'h33C00000,
                       0, 1, 32'h3F800000, 3'b001));
    pend.push_back(dop(32'h7F800000, 32'h3F800000,
                       0, 0, 32'h7F800000, 3'b000));
    pend.push_back(dop(32'h00000000, 32'h3F800000,
                       1, 0, 32'hBF800000, 3'b000));
    pend.push_back(dop(32'h00800001, 32'h00800000,
                       1, 0, 32'h00000000, 3'b001));
    pend.push_back(dop(32'h00000001, 32'h3F800000,
                       0, 0, 32'h3F800000, 3'b000));
    feed(100, 100);
    drain();

    // Eight back-to-back pairs, consumer stalls mid-stream.
    saw_stall = 0;
    for (int i = 0; i < 8; i++) pend.push_back(rnd_op());
    for (int i = 0; i < 40; i++) begin
      if (pend.size() == 0 && sb_q.size() == 0) break;
      cycle(!(i >= 4 && i < 9), 1);
    end
    check("stall_seen", saw_stall, 1);
    drain();

    // Reset with operations in flight.
    for (int i = 0; i < 8; i++) pend.push_back(rnd_op());
    repeat (4) cycle(1, 1);
    rst_n = 0;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    pend.delete();
    sb_q.delete();
    presenting = 0;
    stalled = 0;
    bus.in_valid = 0;
    @(posedge clk);
    #2 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 0);
      check("post_rst", bus.out_valid, 0);
    end

    for (int i = 0; i < 300; i++) pend.push_back(rnd_op());
    feed(75, 80);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpa_pipe.md
Name: fpa_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; next generation of the team's combinational single-precision adder.
- Generic exponent/mantissa widths and a runtime add/sub select.
- Selectable rounding: round-to-nearest-even or truncate.
- Status flags; valid/ready handshake on both sides, so it drops into streaming datapaths between producer and consumer blocks.

Parameters:
- EXP_W, 8: exponent field width (≥3).
- MAN_W, 23: stored fraction width (≥2); word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- number_A  in  W  operand A
- number_B  in  W  operand B
- sub  in  1  0: A+B, 1: A−B (B sign inverted at entry)
- rnd_mode  in  1  0: round-to-nearest-even, 1: truncate toward zero
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- number_out  out  W  result
- flag_invalid  out  1  NaN operand or inf−inf
- flag_overflow  out  1  result overflowed to infinity
- flag_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, number_out=0, all flags=0, all internal stage valids=0. in_ready=1 after reset.
- Reset mid-operation discards all in-flight operations with no output.
- Handshake: transfer occurs on valid&ready at the clock edge.
  - Global stall enable: en = ~out_valid | out_ready; in_ready = en.
  - When en=0, every stage register holds its value.
  - number_out and flags stay stable while out_valid=1 and out_ready=0.
  - in_valid=0 with en=1 injects a bubble.
- Latency: exactly 3 cycles from input handshake to out_valid with no stall; throughput 1 per cycle.
- Stage 1, unpack/classify/align:
  - Classify zero, inf, NaN. Subnormal inputs (exp=0) are flushed to signed zero.
  - Restore the hidden bit; order operands by magnitude (exp, then fraction).
  - Right-shift the smaller operand by the exponent difference, keeping guard, round and sticky bits. Shift ≥ MAN_W+3 leaves sticky only.
  - Special-case results are computed here and carried alongside.
- Stage 2, add: effective subtract when signs differ after sub is applied. Magnitude add/subtract on MAN_W+4 bits with a carry bit.
- Stage 3, normalise/round/pack:
  - Carry-out: right-shift by 1, exp+1.
  - Otherwise: leading-zero count and left shift, exp−lzc.
  - RNE: increment if G&(R|S|lsb). Truncate never increments. Rounding carry renormalises.
  - Inexact = G|R|S after normalisation.
  - Biased exponent ≥ 2^EXP_W−1: overflow=1, inexact=1. Result is ±inf in RNE, ±max-finite in truncate.
  - Biased exponent ≤ 0: flush to signed zero, inexact=1.
- Special cases (flags from stage 1):
  - Any NaN operand: canonical qNaN, i.e. sign 0, exp all ones, fraction MSB 1, rest 0. invalid=1.
  - +inf + −inf (effective): canonical qNaN, invalid=1.
  - inf with finite: that inf.
  - Both zero: −0 only if both effective signs are negative, else +0.
  - Exact cancellation x−x: +0.
  - One zero operand: the other operand, exact.
- Flags are registered with number_out and valid only while out_valid=1.

Test Plan (FP32 defaults, RNE unless stated):
- A=0x3F800000, B=0x40000000, sub=0 → 0x40400000 after 3 cycles, all flags 0.
- A=0x3F800000, B=0x3F800000, sub=1 → 0x00000000; A=0x80000000 + B=0x80000000 → 0x80000000.
- A=0x7F800000, B=0xFF800000, sub=0 → 0x7FC00000, flag_invalid=1. A=0x7FC00001 with any B → 0x7FC00000, invalid=1.
- A=B=0x7F7FFFFF, sub=0:
  - RNE → 0x7F800000, overflow=1, inexact=1.
  - rnd_mode=1 → 0x7F7FFFFF, overflow=1.
- Rounding on A=0x3F800000:
  - B=0x33800000 → 0x3F800000, inexact=1 (tie to even).
  - B=0x33C00000 → 0x3F800001, inexact=1.
  - B=0x34000000 → 0x3F800001, inexact=0.
- Backpressure: stream 8 back-to-back pairs, hold out_ready=0 for 5 cycles mid-stream.
  - in_ready drops, outputs stay stable, results arrive in order with none lost or duplicated.
  - Assert rst_n=0 mid-stream: out_valid=0 immediately, no stale results afterwards.
